// File: rtl/taller_buzzer_pkg.sv
// taller_buzzer shared definitions.
// FSM states, register map and bit positions.
package taller_buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_TONE    = 2'd1;
    localparam logic [1:0] ADDR_CADENCE = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_DONE_CLR = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    localparam int COUNT_IRQ_MASK = 8;

endpackage

// File: rtl/taller_buzzer_tick.sv
// taller_buzzer cadence tick prescaler.
// Emits a one-cycle tick every TICK_DIV cycles while running.
module taller_buzzer_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // Free-running divider, zeroed on phase entry and while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/taller_buzzer.sv
// taller_buzzer: Avalon-MM buzzer tone/cadence generator.
// Register file, shadows, burst FSM, tone generator, read mux.
module taller_buzzer
    import taller_buzzer_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        out_port
);

    logic [15:0] tone_reg;
    logic [15:0] on_reg;
    logic [15:0] off_reg;
    logic [7:0]  beeps_reg;
    logic        irq_mask;

    logic [15:0] sh_half;
    logic [15:0] sh_on;
    logic [15:0] sh_off;
    logic [7:0]  sh_beeps;

    logic [7:0]  remaining;
    logic        done;
    logic [15:0] ms_cnt;
    logic [15:0] tone_cnt;

    state_t state_q;
    state_t state_d;

    logic        wr;
    logic        ctrl_wr;
    logic        start_req;
    logic        stop_req;
    logic        clr_req;
    logic        tick;
    logic        restart;
    logic        load;
    logic        set_done;
    logic        dec_rem;
    logic        clr_rem;
    logic        phase_last;
    logic [15:0] eff_on;
    logic [15:0] eff_off;
    logic [15:0] len_m1;

    assign wr        = chipselect && !write_n;
    assign ctrl_wr   = wr && (address == ADDR_CTRL);
    assign start_req = ctrl_wr && writedata[CTRL_START];
    assign stop_req  = ctrl_wr && writedata[CTRL_STOP];
    assign clr_req   = ctrl_wr && writedata[CTRL_DONE_CLR];

    assign eff_on  = (sh_on == 16'd0) ? 16'd1 : sh_on;
    assign eff_off = (sh_off == 16'd0) ? 16'd1 : sh_off;
    assign len_m1  = ((state_q == ST_OFF) ? eff_off : eff_on) - 16'd1;
    assign phase_last = tick && (ms_cnt == len_m1);

    assign irq = done & irq_mask;

    taller_buzzer_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .run     (state_q != ST_IDLE),
        .restart (restart),
        .tick    (tick)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and phase-transition strobes; STOP overrides all.
    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        load     = 1'b0;
        set_done = 1'b0;
        dec_rem  = 1'b0;
        clr_rem  = 1'b0;
        if (stop_req) begin
            state_d = ST_IDLE;
            clr_rem = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_d = ST_ON;
                        load    = 1'b1;
                        restart = 1'b1;
                    end
                end
                ST_ON: begin
                    if (phase_last) begin
                        if (sh_beeps != 8'd0 && remaining == 8'd1) begin
                            state_d  = ST_IDLE;
                            set_done = 1'b1;
                        end else begin
                            state_d = ST_OFF;
                            restart = 1'b1;
                            dec_rem = (sh_beeps != 8'd0);
                        end
                    end
                end
                ST_OFF: begin
                    if (phase_last) begin
                        state_d = ST_ON;
                        restart = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_reg  <= '0;
            on_reg    <= '0;
            off_reg   <= '0;
            beeps_reg <= '0;
            irq_mask  <= 1'b0;
        end else if (wr) begin
            unique case (address)
                ADDR_TONE: tone_reg <= writedata[15:0];
                ADDR_CADENCE: begin
                    on_reg  <= writedata[15:0];
                    off_reg <= writedata[31:16];
                end
                ADDR_COUNT: begin
                    beeps_reg <= writedata[7:0];
                    irq_mask  <= writedata[COUNT_IRQ_MASK];
                end
                default: ;
            endcase
        end
    end

    // Burst shadows and remaining-beep count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_half   <= '0;
            sh_on     <= '0;
            sh_off    <= '0;
            sh_beeps  <= '0;
            remaining <= '0;
        end else begin
            if (load) begin
                sh_half   <= tone_reg;
                sh_on     <= on_reg;
                sh_off    <= off_reg;
                sh_beeps  <= beeps_reg;
                remaining <= beeps_reg;
            end else if (clr_rem) begin
                remaining <= '0;
            end else if (dec_rem) begin
                remaining <= remaining - 8'd1;
            end
        end
    end

    // Completion flag; a same-cycle set beats DONE_CLR.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else if (set_done) begin
            done <= 1'b1;
        end else if (clr_req) begin
            done <= 1'b0;
        end
    end

    // Tick counter within the current phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_cnt <= '0;
        end else if (restart || state_d == ST_IDLE) begin
            ms_cnt <= '0;
        end else if (tick) begin
            ms_cnt <= ms_cnt + 16'd1;
        end
    end

    // Square-wave tone; low outside ON and restarted at each ON entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_cnt <= '0;
            out_port <= 1'b0;
        end else if (state_d != ST_ON || restart) begin
            tone_cnt <= '0;
            out_port <= 1'b0;
        end else if (sh_half == 16'd0) begin
            tone_cnt <= '0;
            out_port <= 1'b0;
        end else if (tone_cnt == sh_half - 16'd1) begin
            tone_cnt <= '0;
            out_port <= ~out_port;
        end else begin
            tone_cnt <= tone_cnt + 16'd1;
        end
    end

    // Registered read mux, refreshed every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            unique case (address)
                ADDR_CTRL:    readdata <= {30'd0, done, state_q != ST_IDLE};
                ADDR_TONE:    readdata <= {16'd0, tone_reg};
                ADDR_CADENCE: readdata <= {off_reg, on_reg};
                ADDR_COUNT:   readdata <= {23'd0, irq_mask, beeps_reg};
                default:      readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_taller_buzzer.sv
// taller_buzzer bench: random bursts against a timeline model.
// Directed cases for clear, stop, collisions and reset.
module tb_taller_buzzer;

    localparam int TD = 4;
    localparam int INF = 1 << 30;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        out_port;

    int n_tests = 0;
    int n_fail  = 0;

    taller_buzzer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // One edge; bus write on that edge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One edge; readdata then holds the word at address a.
    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    // Tone level t cycles after START from the burst timeline.
    function automatic logic exp_out(int t, int hp, int lon, int loff,
                                     int total);
        int u;
        if (t >= total) return 1'b0;
        u = t % (lon + loff);
        if (u >= lon || hp == 0) return 1'b0;
        return ((u / hp) % 2) == 1;
    endfunction

    // Program, start and follow a burst for `steps` edges.
    // If inj >= 0: write TONE=5 at inj, START again at inj+1.
    task automatic run_burst(input int hp, input int on, input int off,
                             input int beeps, input logic mask,
                             input int steps, input int inj);
        int lon, loff, total;
        bit skip;
        logic [31:0] rd_exp;
        lon   = ((on == 0) ? 1 : on) * TD;
        loff  = ((off == 0) ? 1 : off) * TD;
        total = (beeps == 0) ? INF : beeps * lon + (beeps - 1) * loff;
        bus_wr(2'd1, 32'(hp));
        bus_wr(2'd2, {16'(off), 16'(on)});
        bus_wr(2'd3, {23'd0, mask, 8'(beeps)});
        bus_wr(2'd0, 32'h4);
        bus_wr(2'd0, 32'h1);
        skip = 1'b0;
        for (int t = 0; t <= steps; t++) begin
            check("out", {31'd0, out_port},
                  {31'd0, exp_out(t, hp, lon, loff, total)});
            check("irq", {31'd0, irq},
                  {31'd0, (t >= total) && mask});
            if (!skip) begin
                if (t == 0) rd_exp = 32'd0;
                else rd_exp = ((t - 1) >= total) ? 32'd2 : 32'd1;
                check("status", readdata, rd_exp);
            end
            if (t == inj) begin
                bus_wr(2'd1, 32'd5);
                skip = 1'b1;
            end else if (inj >= 0 && t == inj + 1) begin
                bus_wr(2'd0, 32'h1);
                skip = 1'b0;
            end else begin
                step();
                skip = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int hp, on, off, bp;
        logic mk;

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (3) step();
        check("rst_out", {31'd0, out_port}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rd", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Basic 2-beep burst; then DONE_CLR.
        run_burst(2, 3, 2, 2, 1'b1, 35, -1);
        bus_wr(2'd0, 32'h4);
        check("clr_irq", {31'd0, irq}, 32'd0);
        bus_rd(2'd0, d);
        check("clr_ctrl", d, 32'd0);

        // Continuous mode then STOP.
        run_burst(3, 2, 1, 0, 1'b1, 100, -1);
        bus_wr(2'd0, 32'h2);
        check("stop_out", {31'd0, out_port}, 32'd0);
        check("stop_irq", {31'd0, irq}, 32'd0);
        bus_rd(2'd0, d);
        check("stop_ctrl", d, 32'd0);
        repeat (10) step();
        check("stop_hold", {31'd0, out_port}, 32'd0);

        // Writes during a burst affect only the next START.
        run_burst(2, 3, 2, 2, 1'b0, 35, 5);
        bus_rd(2'd1, d);
        check("tone_rb", d, 32'd5);

        // START|STOP while idle stays idle.
        bus_wr(2'd0, 32'h4);
        bus_wr(2'd0, 32'h3);
        repeat (3) step();
        check("ss_out", {31'd0, out_port}, 32'd0);
        bus_rd(2'd0, d);
        check("ss_ctrl", d, 32'd0);

        // All-zero configuration.
        run_burst(0, 0, 0, 1, 1'b1, 8, -1);

        // Random bursts.
        for (int i = 0; i < 8; i++) begin
            hp  = $urandom_range(0, 4);
            on  = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            bp  = $urandom_range(1, 3);
            mk  = 1'($urandom_range(0, 1));
            run_burst(hp, on, off, bp, mk,
                      bp * ((on == 0) ? 1 : on) * TD
                      + (bp - 1) * ((off == 0) ? 1 : off) * TD + 3, -1);
            bus_rd(2'd2, d);
            check("cad_rb", d, {16'(off), 16'(on)});
            bus_rd(2'd3, d);
            check("cnt_rb", d, {23'd0, mk, 8'(bp)});
        end

        // Reset in the middle of a burst.
        run_burst(1, 3, 2, 3, 1'b1, 7, -1);
        @(negedge clk);
        reset = 1'b1;
        step();
        @(negedge clk);
        reset = 1'b0;
        check("mr_out", {31'd0, out_port}, 32'd0);
        check("mr_irq", {31'd0, irq}, 32'd0);
        check("mr_rd", readdata, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a), d);
            check("mr_reg", d, 32'd0);
        end
        repeat (6) step();
        check("mr_quiet", {31'd0, out_port}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/taller_buzzer.md
# taller_buzzer

Avalon-MM slave output peripheral that drives the alarm buzzer pin with a programmable square-wave tone, gated by an on/off beep cadence. It is the output-side counterpart of the button input PIO in the `taller` system. Software programs the tone, cadence and beep count, then writes START. The block generates the burst autonomously and raises an interrupt when a finite burst completes.

## Interface
- `TICK_DIV`, default 50000: clk cycles per cadence tick (1 ms at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs on a cycle with `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; reset 0.
- `irq`  out  1  `done & irq_mask`; reset 0.
- `out_port`  out  1  buzzer drive; reset 0.

## Operation
- Register map:
  - addr 0 CTRL
    - Write: bit0 START, bit1 STOP, bit2 DONE_CLR (write-1 pulses).
    - Read: bit0 busy, bit1 done.
  - addr 1 TONE: [15:0] half_period in clk cycles; read back [15:0], upper bits 0.
  - addr 2 CADENCE: [15:0] on_len, [31:16] off_len, both in ticks; read back full word.
  - addr 3 COUNT
    - [7:0] beeps; 0 means continuous until STOP.
    - bit8 irq_mask.
    - Read back {23'b0, irq_mask, beeps}.
- Shadow latching: on START, TONE, CADENCE and beeps are copied into shadow registers. Writes while busy affect only the next START. irq_mask is live.
- Zero-length handling:
  - on_len = 0 and off_len = 0 are each treated as 1.
  - half_period = 0 means silent: out_port is held 0 during ON, but cadence timing still runs.
- FSM states: IDLE, ON, OFF.
  - IDLE → ON on START. Loads the shadows, sets remaining = beeps, clears the tick prescaler, ms counter and tone counter.
  - ON:
    - Tone counter counts 0..half_period-1; out_port toggles on wrap.
    - After on_len ticks: if beeps ≠ 0 and remaining = 1, go to IDLE and set done. Otherwise decrement remaining (finite mode only) and go to OFF.
  - OFF: out_port = 0. After off_len ticks, go to ON; the tone counter restarts from 0 with out_port = 0.
- Tick prescaler: counts 0..TICK_DIV-1 only when not IDLE and restarts at 0 on every phase entry. Each phase therefore lasts exactly len·TICK_DIV cycles.
- STOP: from any state → IDLE. Sets out_port = 0 and clears remaining; done is not set.
- Write collisions:
  - START while busy is ignored.
  - START and STOP in the same write: STOP wins, and the block stays or goes IDLE.
  - DONE_CLR in the same cycle as done being set: set wins.
- readdata register: updated every clock from the address mux, independent of chipselect. Unused bits read 0.

## Timing
- Register writes take effect on the clk edge where the write is sampled (edge N).
- Reads: readdata is valid one cycle after the address is presented (1 wait state, registered).
- START sampled at edge N:
  - busy reads 1 for an address presented at N+1 or later.
  - State is ON from edge N.
  - First out_port rise at edge N+half_period; toggles every half_period thereafter.
- Burst length:
  - Finite burst of B beeps: done is set at edge N + B·on_len·TICK_DIV + (B-1)·off_len·TICK_DIV.
  - At that same edge busy becomes 0, out_port becomes 0, and irq becomes 1 if irq_mask is set.
- ON ending mid-tone: out_port is forced to 0 at the phase-exit edge.
- STOP sampled at edge M: out_port = 0 and state = IDLE from edge M.
- Reset at any point: all registers, shadows, counters, FSM, readdata, out_port and irq go to 0 on the next edge.

## Structure
- Shared package `taller_buzzer_pkg` holds:
  - the state enum (IDLE/ON/OFF);
  - the register address constants (CTRL = 0, TONE = 1, CADENCE = 2, COUNT = 3);
  - the CTRL bit indices (START = 0, STOP = 1, DONE_CLR = 2; status busy = 0, done = 1);
  - the COUNT irq_mask bit index (8).
- Sub-module `taller_buzzer_tick`: prescaler with inputs `clk`, `reset`, `run`, `restart` and output `tick` (one-cycle pulse every TICK_DIV cycles while run).
- Top module contains the register file, shadows, FSM, ms counter, tone counter and read mux.

## Test plan
- **Basic 2-beep burst.** TICK_DIV=4, TONE=2, CADENCE on=3/off=2, COUNT=2 with irq_mask=1, START at edge N:
  - out_port toggles every 2 cycles for N..N+12;
  - out_port is 0 for N+12..N+20;
  - out_port toggles again N+20..N+32;
  - done, irq = 1 and busy = 0 at N+32.
- **DONE_CLR.** After the previous scenario, write CTRL DONE_CLR → irq = 0. A readback of CTRL returns 0.
- **Continuous mode with STOP.** beeps = 0, START, wait 100 cycles, then STOP → out_port = 0 and busy = 0 at the STOP edge, done stays 0, irq stays 0.
- **Shadow and collision rules.**
  - During a burst, write TONE=5 and issue START again → the tone period is unchanged and the burst length is unaffected.
  - Write START|STOP while IDLE → busy stays 0.
- **Zero values.** TONE=0, on_len=0, off_len=0, beeps=1 → out_port stays 0 and done is set exactly TICK_DIV cycles after START.
- **Mid-burst reset.** Assert reset mid-burst for 1 cycle → the next edge shows out_port = 0, irq = 0, readdata = 0. Every register reads 0 afterwards.
